// File: rtl/icap_loader_pkg.sv
// Shared types and helpers for the ICAP stream loader.
// Holds the loader state encoding, the sync word and the per-byte bit swap.
package icap_loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        LOAD,
        END
    } state_t;

    localparam logic [31:0] SYNC_WORD = 32'hAA995566;

    // ICAP expects bit 0 of each file byte on the MSB of that byte lane
    function automatic logic [31:0] bit_swap(input logic [31:0] w);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 8; i++) begin
                r[8*b+i] = w[8*b+7-i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/icap_loader_fifo.sv
// Show-ahead FIFO of 32-bit words plus a last flag.
// Writes at full and reads at empty are dropped.
module icap_loader_fifo
    import icap_loader_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    input  logic        wr_last,
    input  logic        rd_en,
    output logic [31:0] rd_data,
    output logic        rd_last,
    output logic        full,
    output logic        empty
);

    localparam int AW = $clog2(DEPTH);

    logic [32:0]   mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   cnt;
    logic          do_wr;
    logic          do_rd;

    assign full  = (cnt == (AW+1)'(DEPTH));
    assign empty = (cnt == '0);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    assign {rd_last, rd_data} = mem[rp];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_wr) wp <= wp + 1'b1;
            if (do_rd) rp <= rp + 1'b1;
            unique case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wp] <= {wr_last, wr_data};
    end

endmodule

// File: rtl/icap_stream_loader.sv
// Streams a partial bitstream from a valid/ready source into ICAPE2/ICAPE3.
// Define ICAP_SYNC_CHECK_EN to build the advisory sync-word window check.
module icap_stream_loader
    import icap_loader_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int COUNT_W     = 24,
    parameter int BIT_SWAP    = 1,
    parameter int SYNC_WINDOW = 64
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               START,
    input  logic [31:0]        S_DATA,
    input  logic               S_VALID,
    input  logic               S_LAST,
    output logic               S_READY,
    output logic               BUSY,
    output logic               DONE,
    output logic               ERR,
    output logic [COUNT_W-1:0] WORD_COUNT,
    output logic               ICAP_CSIB,
    output logic               ICAP_RDWRB,
    output logic [31:0]        ICAP_I
);

    state_t       state;
    logic         last_seen;
    logic         tail_popped;
    logic         fifo_full;
    logic         fifo_empty;
    logic [31:0]  rd_data;
    logic         rd_last;
    logic         push;
    logic         pop;

    assign S_READY = (state == LOAD) && !last_seen && !fifo_full;
    assign push    = S_VALID && S_READY;
    assign pop     = (state == LOAD) && !fifo_empty;
    assign BUSY    = (state != IDLE);

    icap_loader_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (CLK),
        .rst_n  (RST_N),
        .wr_en  (push),
        .wr_data(S_DATA),
        .wr_last(S_LAST),
        .rd_en  (pop),
        .rd_data(rd_data),
        .rd_last(rd_last),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= IDLE;
            last_seen   <= 1'b0;
            tail_popped <= 1'b0;
            DONE        <= 1'b0;
            WORD_COUNT  <= '0;
            ICAP_CSIB   <= 1'b1;
            ICAP_RDWRB  <= 1'b1;
            ICAP_I      <= '0;
        end else begin
            DONE <= 1'b0;
            if (!ICAP_CSIB && WORD_COUNT != {COUNT_W{1'b1}})
                WORD_COUNT <= WORD_COUNT + 1'b1;
            unique case (state)
                IDLE: begin
                    if (START) begin
                        state       <= ARM;
                        ICAP_RDWRB  <= 1'b0;
                        WORD_COUNT  <= '0;
                        last_seen   <= 1'b0;
                        tail_popped <= 1'b0;
                    end
                end
                ARM: begin
                    state <= LOAD;
                end
                LOAD: begin
                    if (push && S_LAST) last_seen <= 1'b1;
                    if (pop) begin
                        ICAP_I    <= (BIT_SWAP != 0) ? bit_swap(rd_data) : rd_data;
                        ICAP_CSIB <= 1'b0;
                        if (rd_last) tail_popped <= 1'b1;
                    end else begin
                        // the tail word has left an empty FIFO: load is drained
                        ICAP_CSIB <= 1'b1;
                        if (tail_popped) state <= END;
                    end
                end
                END: begin
                    ICAP_CSIB  <= 1'b1;
                    ICAP_RDWRB <= 1'b1;
                    DONE       <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ICAP_SYNC_CHECK_EN
    localparam int WIN_W = $clog2(SYNC_WINDOW + 1);

    logic             err;
    logic             matched;
    logic [WIN_W-1:0] win;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            err     <= 1'b0;
            matched <= 1'b0;
            win     <= '0;
        end else if (state == IDLE && START) begin
            err     <= 1'b0;
            matched <= 1'b0;
            win     <= '0;
        end else begin
            if (push && !matched) begin
                if (S_DATA == SYNC_WORD)
                    matched <= 1'b1;
                else if (win == WIN_W'(SYNC_WINDOW - 1))
                    err <= 1'b1;
                if (win != WIN_W'(SYNC_WINDOW))
                    win <= win + 1'b1;
            end
            if (state == END && !matched) err <= 1'b1;
        end
    end

    assign ERR = err;
`else
    assign ERR = 1'b0;
`endif

endmodule

// File: doc/icap_stream_loader.md
Name: icap_stream_loader

Overview:
Upstream feeder for the ICAPE2/ICAPE3 wrapper. It accepts a partial-bitstream word stream from a RIFFA RX channel through a valid/ready handshake and buffers it in a small FIFO. It bit-swaps each byte as the ICAP requires and drives CSIB, RDWRB and I with correct ICAP write sequencing. It also reports busy, done, error and the number of words delivered.

Parameters:
FIFO_DEPTH, 16, FIFO entries; power of 2, minimum 4.
COUNT_W, 24, width of WORD_COUNT.
BIT_SWAP, 1, 1 = reverse bit order within each byte before ICAP_I; 0 = pass through.
SYNC_WINDOW, 64, number of words searched for the sync word (used only with the optional feature).

Ports:
CLK  in  1  sole clock; also clocks the ICAP primitive.
RST_N  in  1  asynchronous active-low reset.
START  in  1  one-cycle pulse; starts a load; honoured only in IDLE.
S_DATA  in  32  bitstream word, in file byte order.
S_VALID  in  1  S_DATA valid.
S_LAST  in  1  marks the final word; qualified by S_VALID & S_READY.
S_READY  out  1  loader accepts the word this cycle.
BUSY  out  1  high in every state except IDLE.
DONE  out  1  one-cycle pulse when a load completes.
ERR  out  1  sticky sync error; cleared by START.
WORD_COUNT  out  COUNT_W  words written to ICAP since the last START; saturating.
ICAP_CSIB  out  1  to ICAPE2.CSIB; active low.
ICAP_RDWRB  out  1  to ICAPE2.RDWRB; 0 = write.
ICAP_I  out  32  to ICAPE2.I.

Behaviour:
- Reset values: S_READY=0, BUSY=0, DONE=0, ERR=0, WORD_COUNT=0, ICAP_CSIB=1, ICAP_RDWRB=1, ICAP_I=0, FIFO empty, state IDLE.
- All ICAP outputs are registered directly from flops; there is no combinational path from S_* to ICAP_*.
- States are IDLE, ARM, LOAD, END.
- IDLE: S_READY=0. START moves to ARM and clears WORD_COUNT, ERR and the last-seen flag.
- ARM (1 cycle): ICAP_RDWRB<=0 while ICAP_CSIB stays 1. Then move to LOAD. RDWRB therefore never changes while CSIB=0.
- LOAD:
  - S_READY = !fifo_full. A push happens when S_VALID & S_READY.
  - A push at full is never accepted, even if a pop occurs in the same cycle.
  - When the FIFO is non-empty, pop one word per cycle. The registered ICAP_I becomes swap(word) and ICAP_CSIB becomes 0.
  - When the FIFO is empty, ICAP_CSIB becomes 1. This is a gap cycle; RDWRB stays 0.
  - Latency: a word accepted at edge k into an empty FIFO is presented on ICAP_I with CSIB=0 after edge k+1.
  - Accepting S_LAST sets last_seen, and S_READY drops from the next cycle.
  - When last_seen is set and the FIFO is empty, move to END.
- END (1 cycle): ICAP_CSIB=1, ICAP_RDWRB stays 0. On the next edge: ICAP_RDWRB<=1, DONE=1 for one cycle, return to IDLE.
- WORD_COUNT increments on every cycle the registered CSIB is 0 and saturates at all-ones.
- Swap with BIT_SWAP=1: ICAP_I[8b+i] = S_DATA[8b+7-i] for b in 0..3, i in 0..7.
- START outside IDLE is ignored. S_VALID outside LOAD is ignored; the word is not consumed.
- Simultaneous push and pop with the FIFO neither full nor empty: occupancy is unchanged.
- A single-word load with S_LAST on the first word is legal.
- Reset mid-load: asynchronously forces CSIB=1 and RDWRB=1 and empties the FIFO. Any partially written bitstream is abandoned.

Optional Feature:
Macro ICAP_SYNC_CHECK_EN.
- Defined: each pushed S_DATA (before the swap) is compared with 32'hAA995566.
  - If no match occurs within the first SYNC_WINDOW accepted words, ERR goes 1 (sticky).
  - A load that ends before a match also sets ERR, at the END cycle.
  - Words are still forwarded to ICAP; ERR is advisory only.
- Undefined: no comparator or window counter is built, and ERR is tied to 0.

Decomposition:
- Package icap_loader_pkg contains:
  - the state enum (IDLE, ARM, LOAD, END);
  - the constant SYNC_WORD = 32'hAA995566;
  - a function for the per-byte bit swap.
- Sub-module icap_loader_fifo: synchronous FIFO of FIFO_DEPTH x 32 bits plus a last bit, with full/empty flags and show-ahead read. It is reset by RST_N.

Test Plan:
- Reset, then START, then 3 words 32'h000000FF, 32'hAA995566, 32'h01234567 with S_LAST on the third.
  - ARM cycle: RDWRB=0, CSIB=1.
  - ICAP_I shows 32'h000000FF, 32'h5599AA66, 32'h80C4A2E6 on consecutive CSIB=0 cycles.
  - DONE pulses once, WORD_COUNT=3, RDWRB returns to 1, ERR=0.
- Hold S_VALID=1 and stall the drain (force pushes only during ARM is impossible, so instead burst FIFO_DEPTH+4 words with S_VALID continuous).
  - S_READY never accepts a word at full.
  - All 20 words arrive at ICAP in order with no duplicates.
- Insert gaps in S_VALID (1 on, 2 off).
  - CSIB shows 1-cycle and 2-cycle deasserted gaps.
  - RDWRB never toggles while CSIB=0 anywhere in the trace.
- START pulsed during LOAD → ignored: WORD_COUNT is not cleared and the state is unaffected.
- Assert RST_N=0 for 1 cycle mid-load after 5 words → CSIB=1 and RDWRB=1 immediately (asynchronously), FIFO empty, BUSY=0.
- With ICAP_SYNC_CHECK_EN: send 64 words of 32'hFFFFFFFF with no sync word → ERR=1 after the 64th accepted word.
  - A following START clears ERR.
  - A run with the sync word at word 10 → ERR stays 0.
